// File: rtl/flash_byte_read_sm_if.sv
// rtl/flash_byte_read_sm_if.sv - arbiter-side and Avalon-MM flash signals of the byte-read state machine
interface flash_byte_read_sm_if #(
    parameter int N      = 32,
    parameter int M      = 8,
    parameter int ADDR_W = 23
);
    logic              start;
    logic [N-1:0]      arguments;
    logic              finished;
    logic [M-1:0]      data_out;
    logic              timeout_err;
    logic              busy;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic [5:0]        flash_mem_burstcount;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    // slave: the state machine itself; master: arbiter plus flash environment
    modport slave (
        input  start, arguments,
        input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        output finished, data_out, timeout_err, busy,
        output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount
    );

    modport master (
        output start, arguments,
        output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        input  finished, data_out, timeout_err, busy,
        input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount
    );
endinterface

// File: rtl/flash_byte_read_sm.sv
// rtl/flash_byte_read_sm.sv - single Avalon-MM word read from flash returning one addressed byte
module flash_byte_read_sm #(
    parameter int N       = 32,
    parameter int M       = 8,
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 255
) (
    input  logic                 sm_clk,
    input  logic                 reset,
    flash_byte_read_sm_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    if (N < ADDR_W + 2) begin : g_bad_width
        $error("flash_byte_read_sm: N must be at least ADDR_W+2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     counter;
    logic [1:0]        lane;
    logic              finished_q;
    logic [M-1:0]      data_q;
    logic              timeout_q;
    logic              busy_q;
    logic              read_q;
    logic [ADDR_W-1:0] address_q;
    logic [7:0]        lane_byte;
    logic              unused_args;

    assign lane_byte   = bus.flash_mem_readdata[{lane, 3'b000} +: 8];
    assign unused_args = ^bus.arguments;

    always_ff @(posedge sm_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            lane       <= '0;
            finished_q <= 1'b0;
            data_q     <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            read_q     <= 1'b0;
            address_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    finished_q <= 1'b0;
                    if (bus.start) begin
                        address_q <= bus.arguments[ADDR_W+1:2];
                        lane      <= bus.arguments[1:0];
                        read_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // read and address must stay frozen while the slave stalls
                    if (!bus.flash_mem_waitrequest) begin
                        read_q  <= 1'b0;
                        counter <= '0;
                        state   <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    counter <= counter + 1'b1;
                    if (bus.flash_mem_readdatavalid) begin
                        data_q     <= M'(lane_byte);
                        timeout_q  <= 1'b0;
                        finished_q <= 1'b1;
                        state      <= DONE;
                    end else if (counter == CW'(TIMEOUT)) begin
                        data_q     <= '0;
                        timeout_q  <= 1'b1;
                        finished_q <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    finished_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.finished             = finished_q;
    assign bus.data_out             = data_q;
    assign bus.timeout_err          = timeout_q;
    assign bus.busy                 = busy_q;
    assign bus.flash_mem_read       = read_q;
    assign bus.flash_mem_address    = address_q;
    assign bus.flash_mem_byteenable = 4'b1111;
    assign bus.flash_mem_burstcount = 6'd1;
endmodule
